// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the digit-serial adder controller.
package serial_adder_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;
endpackage

// File: rtl/serial_digit_adder_ctrl_adder.sv
// Plain WIDTH-bit unsigned adder with carry out; the controller reuses it per digit.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/serial_digit_adder_ctrl.sv
// Adds two DIGITS*WIDTH-bit operands one digit per clock through a single
// narrow adder pair, least significant digit first.
module serial_digit_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS,
  localparam int N     = DIGITS * WIDTH,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic [IDX_W-1:0] digit_idx
);
  // Handshake: start is accepted in IDLE or DONE (a/b sampled on that edge);
  // busy stays high for DIGITS cycles, then done pulses for one cycle with
  // sum/cout valid. start seen while busy is ignored.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  sadd_state_t      state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;

  logic [WIDTH-1:0] a_dig, b_dig, s1, s2;
  logic             c1, c2;

  assign a_dig = a_q[idx_q*WIDTH +: WIDTH];
  assign b_dig = b_q[idx_q*WIDTH +: WIDTH];

  adder #(.WIDTH(WIDTH)) u_stage1 (.a(a_dig), .b(b_dig),            .sum(s1), .cout(c1));
  adder #(.WIDTH(WIDTH)) u_stage2 (.a(s1),    .b(WIDTH'(carry_q)),  .sum(s2), .cout(c2));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        acc_d[idx_q*WIDTH +: WIDTH] = s2;
        carry_d = c1 | c2;
        idx_d   = idx_q + 1'b1;
        // Only the final digit publishes; sum never shows a partial result.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_d;
          cout_d  = c1 | c2;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    digit_idx = (state_q == RUN) ? idx_q : '0;
    sum       = sum_q;
    cout      = cout_q;
  end
endmodule

// File: tb/tb_serial_digit_adder_ctrl.sv
// Directed and randomized checks of the digit-serial adder against a plain
// arithmetic model ({cout,sum} = a + b).
module tb_serial_digit_adder_ctrl;
  localparam int WIDTH  = 4;
  localparam int DIGITS = 4;
  localparam int N      = WIDTH * DIGITS;
  localparam int IDX_W  = 2;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [N-1:0]     a, b;
  logic             busy, done, cout;
  logic [N-1:0]     sum;
  logic [IDX_W-1:0] digit_idx;

  int vectors;
  int miscompares;
  logic [N:0] held_q[$];

  serial_digit_adder_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .digit_idx(digit_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; launches one addition and checks every cycle through DONE.
  // glitch_at >= 0 re-pulses start with fresh operands during that RUN cycle.
  task automatic add_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input int glitch_at);
    logic [N:0] exp_res;
    logic [N:0] prev;
    exp_res = {1'b0, op_a} + {1'b0, op_b};
    prev    = held_q[$];
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < DIGITS; i++) begin
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_idx", digit_idx, i);
      chk("run_sum_held", sum, prev[N-1:0]);
      chk("run_cout_held", cout, prev[N]);
      start = (i == glitch_at);
      a     = N'($urandom);
      b     = N'($urandom);
      @(posedge clock);
      @(negedge clock);
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_idx", digit_idx, 0);
    chk("done_sum", sum, exp_res[N-1:0]);
    chk("done_cout", cout, exp_res[N]);
    start = 1'b0;
    held_q.push_back(exp_res);
  endtask

  task automatic idle_cycles(input int n);
    logic [N:0] prev;
    prev = held_q[$];
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sum", sum, prev[N-1:0]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    held_q.push_back('0);
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_idx", digit_idx, 0);
    reset_n = 1'b1;
    idle_cycles(1);

    add_op(16'h1234, 16'h4321, -1);
    idle_cycles(1);
    add_op(16'hFFFF, 16'h0001, -1);
    idle_cycles(1);
    add_op(16'h8000, 16'h8000, -1);
    idle_cycles(1);
    add_op(16'h0999, 16'h0001, -1);
    idle_cycles(1);

    // start re-pulsed mid-run must not spawn a second result
    add_op(16'h2468, 16'h1357, 1);
    idle_cycles(3);

    // back-to-back: second start is driven during the DONE cycle
    add_op(16'h0F0F, 16'hF0F1, -1);
    add_op(16'h0001, 16'h0002, -1);
    idle_cycles(1);

    // reset after two digits: outputs clear at once, no done pulse follows
    start = 1'b1;
    a     = 16'hABCD;
    b     = 16'h1111;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_idx", digit_idx, 0);
    @(negedge clock);
    reset_n = 1'b1;
    held_q.push_back('0);
    idle_cycles(DIGITS + 1);
    add_op(16'h7FFF, 16'h7FFF, -1);

    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      add_op(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DIGITS - 1)) : -1);
      if (gap > 0) idle_cycles(gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
